sat_reduce_sched: RTL and testbench
===================================

SAT_REDUCE_SCHED -- requirements
Module: sat_reduce_sched

Interface
REQ-001 Parameter NCHAN, default 4: number of requesting channels (2..8).
REQ-002 Parameter IWIDTH, default 24: input sample width.
REQ-003 Parameter OWIDTH, default 16: output sample width, OWIDTH < IWIDTH.
REQ-004 Parameter CNTWIDTH, default 16: clip-counter width.
REQ-005 clk  input  1: single clock; all logic on rising edge.
REQ-006 rst_n  input  1: reset, asynchronous, active-low.
REQ-007 in_data  input  NCHAN*IWIDTH: channel k sample in bits [k*IWIDTH +: IWIDTH], two's complement.
REQ-008 in_valid  input  NCHAN: channel k sample present.
REQ-009 in_ready  output  NCHAN: channel k sample accepted this cycle (one-hot or zero).
REQ-010 out_data  output  OWIDTH: reduced sample, two's complement.
REQ-011 out_chan  output  clog2(NCHAN): source channel of out_data.
REQ-012 out_clip  output  1: out_data was saturated.
REQ-013 out_valid  output  1: out_data/out_chan/out_clip valid.
REQ-014 out_ready  input  1: downstream accepts when high with out_valid.
REQ-015 cnt_sel  input  clog2(NCHAN): clip counter read select.
REQ-016 cnt_value  output  CNTWIDTH: clip count of channel cnt_sel, combinational read of counter register.
REQ-017 cnt_clear  input  1: synchronous clear of all clip counters.

Function
REQ-018 Shared reducer: sign=0 and any of bits [IWIDTH-2:OWIDTH-1] set -> 0x7FFF..., clip=1; sign=1 and not all those bits set -> 0x8000..., clip=1; else low OWIDTH bits, clip=0.
REQ-019 Single output register, two states: EMPTY (out_valid=0), FULL (out_valid=1).
REQ-020 Grant possible when EMPTY, or FULL with out_ready=1 (pass-through, one sample per cycle sustained).
REQ-021 Arbitration round-robin: search starts at pointer p, first channel with in_valid high granted; in_ready asserted only for it, in same cycle.
REQ-022 After grant to channel g, p <= (g+1) mod NCHAN; no grant -> p unchanged.
REQ-023 Latency: sample accepted at edge n appears on out_data with out_valid at edge n (registered, visible cycle n+1).
REQ-024 FULL with out_ready=0: all in_ready=0, output register and p held.
REQ-025 FULL, out_ready=1, no in_valid: transition to EMPTY.
REQ-026 in_valid deassertion without ready permitted; no sample is lost or duplicated once in_ready seen high.
REQ-027 Clip counter k increments when a clipped sample of channel k is accepted into output register; saturates at all-ones, no wrap.
REQ-028 cnt_clear and increment same cycle: clear wins, counter 0.

Reset
REQ-029 rst_n low: out_valid=0, out_data=0, out_chan=0, out_clip=0, p=0, state EMPTY, all counters 0, in_ready=0.
REQ-030 Reset mid-transfer discards held sample; first grant after release starts at channel 0.

Configuration
REQ-031 Macro SAT_REDUCE_SCHED_CLIP_COUNT_EN defined: clip counters and cnt_value per REQ-016/027/028.
REQ-032 Macro undefined: no counter registers; cnt_value tied 0; cnt_sel, cnt_clear ignored; datapath unchanged.

Verification
REQ-033 Defaults, ch0 in_data=0x00_7FFF valid, out_ready=1 -> next cycle out_data=0x7FFF, out_chan=0, out_clip=0.
REQ-034 ch1 0x01_0000 -> 0x7FFF clip=1; ch2 0xFF_7FFF -> 0x8000 clip=1; ch3 0xFF_8000 -> 0x8000 clip=0.
REQ-035 All four in_valid held high, out_ready=1 -> out_chan sequence 0,1,2,3,0, one per cycle, no gaps.
REQ-036 out_ready low 5 cycles while FULL -> outputs stable, in_ready all 0, p unchanged; release -> order resumes.
REQ-037 Macro defined, ch2 clip 3 times -> cnt_sel=2 reads 3; cnt_clear with simultaneous clip -> 0; CNTWIDTH=4 with 20 clips -> 15.
REQ-038 rst_n low while FULL mid-stream -> out_valid=0 asynchronously; after release, first grant to lowest valid channel from 0.

Source files
------------

// File: rtl/sat_reduce_sched.sv
// sat_reduce_sched: round-robin scheduler that feeds NCHAN wide samples through
// one shared saturating reducer into a single-entry output register.
// Optional per-channel clip counters are enabled by defining the macro
// SAT_REDUCE_SCHED_CLIP_COUNT_EN; without it cnt_value reads 0.
module sat_reduce_sched #(
  parameter int NCHAN    = 4,
  parameter int IWIDTH   = 24,
  parameter int OWIDTH   = 16,
  parameter int CNTWIDTH = 16,
  localparam int CW      = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NCHAN*IWIDTH-1:0] in_data,
  input  logic [NCHAN-1:0]        in_valid,
  output logic [NCHAN-1:0]        in_ready,
  output logic [OWIDTH-1:0]       out_data,
  output logic [CW-1:0]           out_chan,
  output logic                    out_clip,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic [CW-1:0]           cnt_sel,
  output logic [CNTWIDTH-1:0]     cnt_value,
  input  logic                    cnt_clear
);

  localparam logic [CW:0] NCH_W = (CW+1)'(NCHAN);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [OWIDTH-1:0]   data_q, data_d;
  logic [CW-1:0]       chan_q, chan_d;
  logic                clip_q, clip_d;
  logic [CW-1:0]       p_q, p_d;

  logic [IWIDTH-1:0]   chan_sample [NCHAN];
  logic [NCHAN-1:0]    valid_rot;
  logic                gnt_any;
  logic [CW-1:0]       gnt_off;
  logic [CW:0]         gnt_sum;
  logic [CW-1:0]       gnt_idx;
  logic                can_accept;
  logic                take;
  logic [IWIDTH-1:0]   sample;
  logic [OWIDTH-1:0]   red_data;
  logic                red_clip;

  // Unpack the flat input bus into per-channel samples.
  generate
    for (genvar gi = 0; gi < NCHAN; gi++) begin : g_unpack
      assign chan_sample[gi] = in_data[gi*IWIDTH +: IWIDTH];
    end
  endgenerate

  // Rotate valids so that bit 0 is the channel at the round-robin pointer.
  assign valid_rot = NCHAN'({in_valid, in_valid} >> p_q);

  // Priority search over the rotated valids: lowest offset wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_off = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (valid_rot[i]) begin
        gnt_any = 1'b1;
        gnt_off = CW'(i);
      end
    end
  end

  // Convert the offset back to an absolute channel index modulo NCHAN.
  assign gnt_sum    = {1'b0, p_q} + {1'b0, gnt_off};
  assign gnt_idx    = (gnt_sum >= NCH_W) ? CW'(gnt_sum - NCH_W) : gnt_sum[CW-1:0];

  // The register can take a sample when empty or when it drains this cycle.
  assign can_accept = (state_q == ST_EMPTY) || out_ready;
  assign take       = can_accept && gnt_any;

  // One-hot ready to the granted channel; forced low while in reset.
  generate
    for (genvar gi = 0; gi < NCHAN; gi++) begin : g_ready
      assign in_ready[gi] = rst_n & take & (gnt_idx == CW'(gi));
    end
  endgenerate

  assign sample = chan_sample[gnt_idx];

  // Saturating reduction: guard bits must all equal the sign bit to fit.
  always_comb begin
    red_data = sample[OWIDTH-1:0];
    red_clip = 1'b0;
    if (!sample[IWIDTH-1] && (|sample[IWIDTH-2:OWIDTH-1])) begin
      red_data = {1'b0, {(OWIDTH-1){1'b1}}};
      red_clip = 1'b1;
    end else if (sample[IWIDTH-1] && !(&sample[IWIDTH-2:OWIDTH-1])) begin
      red_data = {1'b1, {(OWIDTH-1){1'b0}}};
      red_clip = 1'b1;
    end
  end

  // Next state of the output register and round-robin pointer.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    chan_d  = chan_q;
    clip_d  = clip_q;
    p_d     = p_q;
    if (take) begin
      state_d = ST_FULL;
      data_d  = red_data;
      chan_d  = gnt_idx;
      clip_d  = red_clip;
      p_d     = (gnt_idx == CW'(NCHAN - 1)) ? '0 : gnt_idx + CW'(1);
    end else if ((state_q == ST_FULL) && out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // EMPTY/FULL state, held sample and pointer; reset discards any held sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      chan_q  <= '0;
      clip_q  <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      clip_q  <= clip_d;
      p_q     <= p_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_clip  = clip_q;

`ifdef SAT_REDUCE_SCHED_CLIP_COUNT_EN
  logic [CNTWIDTH-1:0] cnt_arr [NCHAN];

  generate
    for (genvar gi = 0; gi < NCHAN; gi++) begin : g_cnt
      logic [CNTWIDTH-1:0] cnt_q, cnt_d;

      // Count clipped samples accepted from this channel; clear has priority, no wrap.
      always_comb begin
        cnt_d = cnt_q;
        if (cnt_clear) begin
          cnt_d = '0;
        end else if (take && red_clip && (gnt_idx == CW'(gi)) && (cnt_q != '1)) begin
          cnt_d = cnt_q + CNTWIDTH'(1);
        end
      end

      // Counter register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign cnt_arr[gi] = cnt_q;
    end
  endgenerate

  assign cnt_value = ({1'b0, cnt_sel} < NCH_W) ? cnt_arr[cnt_sel] : '0;
`else
  logic unused_cnt;
  assign unused_cnt = ^{cnt_sel, cnt_clear};
  assign cnt_value  = '0;
`endif

endmodule

// File: tb/tb_sat_reduce_sched.sv
// tb_sat_reduce_sched: randomized and directed checks of sat_reduce_sched
// against an arithmetic reference model (signed clamp, modular round-robin).
module tb_sat_reduce_sched;
  localparam int NCHAN    = 4;
  localparam int IWIDTH   = 24;
  localparam int OWIDTH   = 16;
  localparam int CNTWIDTH = 4;
  localparam int CW       = 2;
  localparam int CNT_MAX  = 15;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NCHAN*IWIDTH-1:0] in_data;
  logic [NCHAN-1:0]        in_valid;
  logic [NCHAN-1:0]        in_ready;
  logic [OWIDTH-1:0]       out_data;
  logic [CW-1:0]           out_chan;
  logic                    out_clip;
  logic                    out_valid;
  logic                    out_ready;
  logic [CW-1:0]           cnt_sel;
  logic [CNTWIDTH-1:0]     cnt_value;
  logic                    cnt_clear;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic        m_full;
  logic [15:0] m_data;
  int          m_chan;
  logic        m_clip;
  int          m_p;
  int          m_cnt [NCHAN];
  int          m_g;
  logic [3:0]  m_ready;
  logic [3:0]  rdy_obs;

  sat_reduce_sched #(
    .NCHAN(NCHAN), .IWIDTH(IWIDTH), .OWIDTH(OWIDTH), .CNTWIDTH(CNTWIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_chan(out_chan),
    .out_clip(out_clip), .out_valid(out_valid), .out_ready(out_ready),
    .cnt_sel(cnt_sel), .cnt_value(cnt_value), .cnt_clear(cnt_clear)
  );

  always #5 clk = ~clk;

  // Clamp a signed sample to the 16-bit range.
  task automatic ref_reduce(input logic [23:0] s, output logic [15:0] d, output logic c);
    int v;
    v = int'($signed(s));
    if (v > 32767) begin
      d = 16'h7FFF; c = 1'b1;
    end else if (v < -32768) begin
      d = 16'h8000; c = 1'b1;
    end else begin
      d = v[15:0]; c = 1'b0;
    end
  endtask

  function automatic int exp_cnt(input int k);
`ifdef SAT_REDUCE_SCHED_CLIP_COUNT_EN
    return m_cnt[k];
`else
    return 0 * k;
`endif
  endfunction

  task automatic model_reset();
    m_full = 1'b0; m_data = '0; m_chan = 0; m_clip = 1'b0; m_p = 0;
    for (int k = 0; k < NCHAN; k++) m_cnt[k] = 0;
  endtask

  // Which channel should be granted for the present inputs.
  task automatic model_predict();
    m_ready = '0;
    m_g = -1;
    if (!m_full || out_ready) begin
      for (int k = 0; k < NCHAN; k++) begin
        int c;
        c = (m_p + k) % NCHAN;
        if (m_g < 0 && in_valid[c]) m_g = c;
      end
    end
    if (m_g >= 0) m_ready[m_g] = 1'b1;
  endtask

  // Apply one clock edge to the model.
  task automatic model_commit();
    logic [15:0] d;
    logic        cl;
    d = '0; cl = 1'b0;
    if (m_g >= 0) begin
      ref_reduce(in_data[m_g*IWIDTH +: IWIDTH], d, cl);
      m_full = 1'b1; m_data = d; m_clip = cl; m_chan = m_g;
      m_p = (m_g + 1) % NCHAN;
    end else if (m_full && out_ready) begin
      m_full = 1'b0;
    end
    for (int k = 0; k < NCHAN; k++) begin
      if (cnt_clear) m_cnt[k] = 0;
      else if (m_g == k && cl && m_cnt[k] < CNT_MAX) m_cnt[k]++;
    end
  endtask

  // Settle, sample ready, advance one edge, move 1ns past the edge.
  task automatic step();
    #1;
    model_predict();
    rdy_obs = in_ready;
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic set_chan(input int k, input logic [23:0] v);
    in_data[k*IWIDTH +: IWIDTH] = v;
  endtask

  function automatic logic [23:0] rnd_sample();
    int v;
    case ($urandom_range(3))
      0:       v = int'($urandom);
      1:       v = 32760 + int'($urandom_range(15));
      2:       v = -32775 + int'($urandom_range(15));
      default: v = int'($urandom_range(65535)) - 32768;
    endcase
    return v[23:0];
  endfunction

  task automatic rnd_all();
    for (int k = 0; k < NCHAN; k++) set_chan(k, rnd_sample());
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = '0; out_ready = 1'b0; cnt_clear = 1'b0; cnt_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 4'hF; out_ready = 1'b1; cnt_clear = 1'b0; cnt_sel = 2'd1;
    in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({out_valid, out_data, out_chan, out_clip} !== '0) begin
      fails++; $display("FAIL reset_out: got v=%b d=%h c=%0d clip=%b want all 0", out_valid, out_data, out_chan, out_clip);
    end
    tests++;
    if (in_ready !== 4'b0000) begin
      fails++; $display("FAIL reset_ready: got %b want 0000", in_ready);
    end
    tests++;
    if (cnt_value !== '0) begin
      fails++; $display("FAIL reset_cnt: got %0d want 0", cnt_value);
    end
    $display("[TB] reset: v=%b d=%h rdy=%b", out_valid, out_data, in_ready);
    in_valid = '0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reduce();
    logic [23:0] vin  [8] = '{24'h007FFF, 24'h010000, 24'hFF7FFF, 24'hFF8000,
                             24'h008000, 24'hFFFFFF, 24'h800000, 24'h000000};
    logic [15:0] vout [8] = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000,
                             16'h7FFF, 16'hFFFF, 16'h8000, 16'h0000};
    logic        vclp [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      int ch;
      ch = i % NCHAN;
      rnd_all();
      set_chan(ch, vin[i]);
      in_valid = 4'(1 << ch);
      step();
      tests++;
      if (rdy_obs !== 4'(1 << ch)) begin
        fails++; $display("FAIL reduce_ready[%0d]: got %b want %b", i, rdy_obs, 4'(1 << ch));
      end
      tests++;
      if ({out_valid, out_data, out_chan, out_clip} !== {1'b1, vout[i], CW'(ch), vclp[i]}) begin
        fails++; $display("FAIL reduce[%0d]: in=%h got v=%b d=%h c=%0d clip=%b want d=%h c=%0d clip=%b",
                          i, vin[i], out_valid, out_data, out_chan, out_clip, vout[i], ch, vclp[i]);
      end
      $display("[TB] reduce ch%0d in=%h -> d=%h clip=%b", ch, vin[i], out_data, out_clip);
    end
    in_valid = '0;
    step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rnd_all();
      step();
      tests++;
      if (rdy_obs !== 4'(1 << (i % NCHAN))) begin
        fails++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, rdy_obs, 4'(1 << (i % NCHAN)));
      end
      tests++;
      if (out_valid !== 1'b1 || out_chan !== CW'(i % NCHAN)) begin
        fails++; $display("FAIL b2b_chan[%0d]: got v=%b c=%0d want v=1 c=%0d", i, out_valid, out_chan, i % NCHAN);
      end
      tests++;
      if ({out_data, out_clip} !== {m_data, m_clip}) begin
        fails++; $display("FAIL b2b_data[%0d]: got %h/%b want %h/%b", i, out_data, out_clip, m_data, m_clip);
      end
      $display("[TB] b2b cycle %0d chan=%0d d=%h", i, out_chan, out_data);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] hd;
    logic [CW-1:0] hc;
    logic hk;
    hd = out_data; hc = out_chan; hk = out_clip;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rnd_all();
      step();
      tests++;
      if (rdy_obs !== 4'b0000) begin
        fails++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, rdy_obs);
      end
      tests++;
      if ({out_valid, out_data, out_chan, out_clip} !== {1'b1, hd, hc, hk}) begin
        fails++; $display("FAIL bp_hold[%0d]: got v=%b d=%h c=%0d want v=1 d=%h c=%0d", i, out_valid, out_data, out_chan, hd, hc);
      end
      $display("[TB] backpressure %0d held d=%h c=%0d", i, out_data, out_chan);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      tests++;
      if (out_valid !== 1'b1 || out_chan !== CW'((int'(hc) + i) % NCHAN)) begin
        fails++; $display("FAIL bp_resume[%0d]: got c=%0d want %0d", i, out_chan, (int'(hc) + i) % NCHAN);
      end
      $display("[TB] resume %0d chan=%0d", i, out_chan);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rnd_all();
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(3) != 0);
      cnt_sel   = CW'($urandom);
      cnt_clear = ($urandom_range(31) == 0);
      step();
      tests++;
      if (rdy_obs !== m_ready) begin
        fails++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, rdy_obs, m_ready);
      end
      tests++;
      if (out_valid !== m_full) begin
        fails++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, out_valid, m_full);
      end
      if (m_full) begin
        tests++;
        if ({out_data, out_chan, out_clip} !== {m_data, CW'(m_chan), m_clip}) begin
          fails++; $display("FAIL rnd_out[%0d]: got d=%h c=%0d clip=%b want d=%h c=%0d clip=%b",
                            i, out_data, out_chan, out_clip, m_data, m_chan, m_clip);
        end
      end
      tests++;
      if (cnt_value !== CNTWIDTH'(exp_cnt(int'(cnt_sel)))) begin
        fails++; $display("FAIL rnd_cnt[%0d]: sel=%0d got %0d want %0d", i, cnt_sel, cnt_value, exp_cnt(int'(cnt_sel)));
      end
      $display("[TB] rnd %0d v=%b rdy=%b out=%b/%h/%0d/%b cnt=%0d", i, in_valid, rdy_obs, out_valid, out_data, out_chan, out_clip, cnt_value);
    end
    cnt_clear = 1'b0;
  endtask

  task automatic test_counters();
    int want3, want0, want15;
`ifdef SAT_REDUCE_SCHED_CLIP_COUNT_EN
    want3 = 3; want0 = 0; want15 = 15;
`else
    want3 = 0; want0 = 0; want15 = 0;
`endif
    do_reset();
    cnt_sel = 2'd2; out_ready = 1'b1; in_valid = 4'b0100;
    set_chan(2, 24'h010000);
    repeat (3) step();
    tests++;
    if (cnt_value !== CNTWIDTH'(want3) || cnt_value !== CNTWIDTH'(exp_cnt(2))) begin
      fails++; $display("FAIL cnt_three: got %0d want %0d", cnt_value, want3);
    end
    $display("[TB] cnt after 3 clips = %0d", cnt_value);
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    tests++;
    if (cnt_value !== CNTWIDTH'(want0)) begin
      fails++; $display("FAIL cnt_clear: got %0d want %0d", cnt_value, want0);
    end
    $display("[TB] cnt after clear+clip = %0d", cnt_value);
    set_chan(2, 24'hF00000);
    repeat (20) step();
    tests++;
    if (cnt_value !== CNTWIDTH'(want15) || cnt_value !== CNTWIDTH'(exp_cnt(2))) begin
      fails++; $display("FAIL cnt_sat: got %0d want %0d", cnt_value, want15);
    end
    $display("[TB] cnt after 20 clips = %0d", cnt_value);
    cnt_sel = 2'd0;
    tests++;
    #1;
    if (cnt_value !== '0) begin
      fails++; $display("FAIL cnt_other: got %0d want 0", cnt_value);
    end
    in_valid = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 4'hF; out_ready = 1'b1;
    rnd_all();
    repeat (3) step();
    out_ready = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 4'b0000) begin
      fails++; $display("FAIL async_reset: got v=%b d=%h rdy=%b want 0/0/0000", out_valid, out_data, in_ready);
    end
    $display("[TB] async reset mid-stream v=%b rdy=%b", out_valid, in_ready);
    @(posedge clk);
    #1;
    model_reset();
    in_valid = 4'b1010;
    rst_n = 1'b1;
    step();
    tests++;
    if (rdy_obs !== 4'b0010) begin
      fails++; $display("FAIL post_reset_ready: got %b want 0010", rdy_obs);
    end
    tests++;
    if (out_valid !== 1'b1 || out_chan !== 2'd1) begin
      fails++; $display("FAIL post_reset_chan: got v=%b c=%0d want v=1 c=1", out_valid, out_chan);
    end
    $display("[TB] first grant after reset chan=%0d", out_chan);
    in_valid = '0;
  endtask

  initial begin
    test_reset();
    test_reduce();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_counters();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
